// File: rtl/eci_chan_buf_pkg.sv
// Shared types and helpers for the ECI channel buffer.
// Beat layout is {data, size, vc} with vc in the LSBs.
package eci_chan_buf_pkg;

    localparam int ECI_PACKET_SIZE_WIDTH  = 5;
    localparam int ECI_CHAN_BUF_CNT_WIDTH = 32;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int beat_width(input int data_w, input int vc_w);
        return data_w + ECI_PACKET_SIZE_WIDTH + vc_w;
    endfunction

endpackage

// File: rtl/eci_chan_fifo.sv
// One ECI channel: synchronous FIFO with occupancy/almost-full reporting.
// Traffic counters are built only when ECI_CHAN_BUF_STATS_EN is defined.
module eci_chan_fifo
    import eci_chan_buf_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int VC_WIDTH     = 4,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            s_data_i,
    input  logic [ECI_PACKET_SIZE_WIDTH-1:0] s_size_i,
    input  logic [VC_WIDTH-1:0]              s_vc_i,
    input  logic                             s_valid_i,
    output logic                             s_ready_o,
    output logic [DATA_WIDTH-1:0]            m_data_o,
    output logic [ECI_PACKET_SIZE_WIDTH-1:0] m_size_o,
    output logic [VC_WIDTH-1:0]              m_vc_o,
    output logic                             m_valid_o,
    input  logic                             m_ready_i,
    output logic [occ_width(DEPTH)-1:0]      occupancy_o,
    output logic                             afull_o
`ifdef ECI_CHAN_BUF_STATS_EN
   ,output logic [ECI_CHAN_BUF_CNT_WIDTH-1:0] pkt_cnt_o,
    output logic [ECI_CHAN_BUF_CNT_WIDTH-1:0] stall_cnt_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = occ_width(DEPTH);
    localparam int BW = beat_width(DATA_WIDTH, VC_WIDTH);

    logic [BW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [OW-1:0] count;
    logic          rst_q;
    logic          push;
    logic          pop;

    // rst_q holds ready low for the first cycle after reset releases
    assign s_ready_o   = ~rst_q & (count != OW'(DEPTH));
    assign m_valid_o   = (count != '0);
    assign push        = s_valid_i & s_ready_o;
    assign pop         = m_valid_o & m_ready_i;
    assign occupancy_o = count;
    assign afull_o     = (count >= OW'(AFULL_THRESH));

    assign {m_data_o, m_size_o, m_vc_o} = m_valid_o ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rst_q  <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s_data_i, s_size_i, s_vc_i};
    end

`ifdef ECI_CHAN_BUF_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_o   <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (pop && pkt_cnt_o != '1)
                pkt_cnt_o <= pkt_cnt_o + 1'b1;
            if (s_valid_i && !s_ready_o && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/eci_chan_buf.sv
// Bundle of independent ECI channel FIFOs on a single clock.
// Define ECI_CHAN_BUF_STATS_EN to add per-channel packet/stall counters.
module eci_chan_buf
    import eci_chan_buf_pkg::*;
#(
    parameter int NUM_CHAN     = 3,
    parameter int DATA_WIDTH   = 64,
    parameter int VC_WIDTH     = 4,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [NUM_CHAN-1:0][DATA_WIDTH-1:0]            s_data_i,
    input  logic [NUM_CHAN-1:0][ECI_PACKET_SIZE_WIDTH-1:0] s_size_i,
    input  logic [NUM_CHAN-1:0][VC_WIDTH-1:0]              s_vc_i,
    input  logic [NUM_CHAN-1:0]                            s_valid_i,
    output logic [NUM_CHAN-1:0]                            s_ready_o,
    output logic [NUM_CHAN-1:0][DATA_WIDTH-1:0]            m_data_o,
    output logic [NUM_CHAN-1:0][ECI_PACKET_SIZE_WIDTH-1:0] m_size_o,
    output logic [NUM_CHAN-1:0][VC_WIDTH-1:0]              m_vc_o,
    output logic [NUM_CHAN-1:0]                            m_valid_o,
    input  logic [NUM_CHAN-1:0]                            m_ready_i,
    output logic [NUM_CHAN-1:0][occ_width(DEPTH)-1:0]      occupancy_o,
    output logic [NUM_CHAN-1:0]                            afull_o
`ifdef ECI_CHAN_BUF_STATS_EN
   ,output logic [NUM_CHAN-1:0][ECI_CHAN_BUF_CNT_WIDTH-1:0] pkt_cnt_o,
    output logic [NUM_CHAN-1:0][ECI_CHAN_BUF_CNT_WIDTH-1:0] stall_cnt_o
`endif
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("eci_chan_buf: DEPTH must be a power of two >= 2");
    end

    if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
        $error("eci_chan_buf: AFULL_THRESH must be in 1..DEPTH");
    end

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        eci_chan_fifo #(
            .DATA_WIDTH   (DATA_WIDTH),
            .VC_WIDTH     (VC_WIDTH),
            .DEPTH        (DEPTH),
            .AFULL_THRESH (AFULL_THRESH)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .s_data_i    (s_data_i[i]),
            .s_size_i    (s_size_i[i]),
            .s_vc_i      (s_vc_i[i]),
            .s_valid_i   (s_valid_i[i]),
            .s_ready_o   (s_ready_o[i]),
            .m_data_o    (m_data_o[i]),
            .m_size_o    (m_size_o[i]),
            .m_vc_o      (m_vc_o[i]),
            .m_valid_o   (m_valid_o[i]),
            .m_ready_i   (m_ready_i[i]),
            .occupancy_o (occupancy_o[i]),
            .afull_o     (afull_o[i])
`ifdef ECI_CHAN_BUF_STATS_EN
           ,.pkt_cnt_o   (pkt_cnt_o[i]),
            .stall_cnt_o (stall_cnt_o[i])
`endif
        );
    end

endmodule

// File: tb/tb_eci_chan_buf.sv
// Randomised bench for eci_chan_buf against a queue-per-channel model.
module tb_eci_chan_buf;
    import eci_chan_buf_pkg::*;

    localparam int NC    = 3;
    localparam int DW    = 64;
    localparam int VW    = 4;
    localparam int DEPTH = 4;
    localparam int AF    = DEPTH - 1;
    localparam int OW    = occ_width(DEPTH);
    localparam int SW    = ECI_PACKET_SIZE_WIDTH;
    localparam int CW    = ECI_CHAN_BUF_CNT_WIDTH;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NC-1:0][DW-1:0]  s_data_i = '0;
    logic [NC-1:0][SW-1:0]  s_size_i = '0;
    logic [NC-1:0][VW-1:0]  s_vc_i = '0;
    logic [NC-1:0]          s_valid_i = '0;
    logic [NC-1:0]          s_ready_o;
    logic [NC-1:0][DW-1:0]  m_data_o;
    logic [NC-1:0][SW-1:0]  m_size_o;
    logic [NC-1:0][VW-1:0]  m_vc_o;
    logic [NC-1:0]          m_valid_o;
    logic [NC-1:0]          m_ready_i = '0;
    logic [NC-1:0][OW-1:0]  occupancy_o;
    logic [NC-1:0]          afull_o;
`ifdef ECI_CHAN_BUF_STATS_EN
    logic [NC-1:0][CW-1:0]  pkt_cnt_o;
    logic [NC-1:0][CW-1:0]  stall_cnt_o;
`endif

    eci_chan_buf #(
        .NUM_CHAN(NC), .DATA_WIDTH(DW), .VC_WIDTH(VW),
        .DEPTH(DEPTH), .AFULL_THRESH(AF)
    ) dut (
        .clk(clk), .reset(reset),
        .s_data_i(s_data_i), .s_size_i(s_size_i), .s_vc_i(s_vc_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .m_data_o(m_data_o), .m_size_o(m_size_o), .m_vc_o(m_vc_o),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .occupancy_o(occupancy_o), .afull_o(afull_o)
`ifdef ECI_CHAN_BUF_STATS_EN
       ,.pkt_cnt_o(pkt_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [VW-1:0] v;
    } beat_t;

    // Model: each channel is a bounded in-order queue; ready is withheld
    // for one cycle after reset is released.
    beat_t       q[NC][$];
    bit          m_rst = 1'b1;
    int unsigned pk[NC];
    int unsigned st[NC];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic cycle();
        bit    rst;
        bit    pu[NC];
        bit    po[NC];
        beat_t b[NC];
        rst = reset;
        for (int c = 0; c < NC; c++) begin
            bit rdy;
            rdy   = !m_rst && (q[c].size() < DEPTH);
            pu[c] = s_valid_i[c] && rdy;
            po[c] = (q[c].size() != 0) && m_ready_i[c];
            b[c]  = {s_data_i[c], s_size_i[c], s_vc_i[c]};
            if (s_valid_i[c] && !rdy) st[c]++;
            if (po[c]) pk[c]++;
        end
        @(posedge clk);
        #1;
        m_rst = rst;
        for (int c = 0; c < NC; c++) begin
            if (rst) begin
                q[c].delete();
                pk[c] = 0;
                st[c] = 0;
            end else begin
                if (po[c]) void'(q[c].pop_front());
                if (pu[c]) q[c].push_back(b[c]);
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        s_valid_i = '0;
        m_ready_i = '0;
        cycle();
        cycle();
        for (int c = 0; c < NC; c++) begin
            vectors++;
            if ({s_ready_o[c], m_valid_o[c], afull_o[c]} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_ctrl ch%0d got rdy/vld/af=%b%b%b want 000",
                         c, s_ready_o[c], m_valid_o[c], afull_o[c]);
            end
            vectors++;
            if (occupancy_o[c] !== '0 || m_data_o[c] !== '0) begin
                miscompares++;
                $display("FAIL reset_data ch%0d got occ=%0d data=%h want 0",
                         c, occupancy_o[c], m_data_o[c]);
            end
`ifdef ECI_CHAN_BUF_STATS_EN
            vectors++;
            if (pkt_cnt_o[c] !== '0 || stall_cnt_o[c] !== '0) begin
                miscompares++;
                $display("FAIL reset_cnt ch%0d got pkt=%0d stall=%0d want 0",
                         c, pkt_cnt_o[c], stall_cnt_o[c]);
            end
`endif
        end
        reset = 1'b0;
        cycle();
        vectors++;
        if (s_ready_o !== '1) begin
            miscompares++;
            $display("FAIL reset_release got s_ready=%b want 111", s_ready_o);
        end
    endtask

    task automatic test_single_beat();
        s_data_i[0]  = 64'h1234;
        s_size_i[0]  = 5'd1;
        s_vc_i[0]    = 4'd6;
        s_valid_i[0] = 1'b1;
        cycle();
        s_valid_i[0] = 1'b0;
        vectors++;
        if (m_valid_o[0] !== 1'b1 || m_data_o[0] !== 64'h1234 ||
            m_size_o[0] !== 5'd1 || m_vc_o[0] !== 4'd6) begin
            miscompares++;
            $display("FAIL single_beat got v=%b d=%h s=%0d vc=%0d want 1 1234 1 6",
                     m_valid_o[0], m_data_o[0], m_size_o[0], m_vc_o[0]);
        end
        cycle();
        vectors++;
        if (occupancy_o[0] !== OW'(1)) begin
            miscompares++;
            $display("FAIL single_occ got %0d want 1", occupancy_o[0]);
        end
        m_ready_i[0] = 1'b1;
        cycle();
        m_ready_i[0] = 1'b0;
        vectors++;
        if (m_valid_o[0] !== 1'b0 || m_data_o[0] !== '0 || occupancy_o[0] !== '0) begin
            miscompares++;
            $display("FAIL single_pop got v=%b d=%h occ=%0d want 0 0 0",
                     m_valid_o[0], m_data_o[0], occupancy_o[0]);
        end
    endtask

    task automatic test_fill();
        m_ready_i[0] = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            s_data_i[0]  = {$urandom, $urandom};
            s_size_i[0]  = SW'($urandom);
            s_vc_i[0]    = VW'($urandom);
            s_valid_i[0] = 1'b1;
            cycle();
            vectors++;
            if (occupancy_o[0] !== OW'(i) || afull_o[0] !== (i >= AF) ||
                s_ready_o[0] !== (i < DEPTH)) begin
                miscompares++;
                $display("FAIL fill_%0d got occ=%0d af=%b rdy=%b want %0d %b %b",
                         i, occupancy_o[0], afull_o[0], s_ready_o[0],
                         i, i >= AF, i < DEPTH);
            end
        end
        s_data_i[0] = 64'hF1F7_0000_0000_0005;
        cycle();
        vectors++;
        if (occupancy_o[0] !== OW'(DEPTH) || s_ready_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_hold got occ=%0d rdy=%b want %0d 0",
                     occupancy_o[0], s_ready_o[0], DEPTH);
        end
        m_ready_i[0] = 1'b1;
        cycle();
        vectors++;
        if (occupancy_o[0] !== OW'(DEPTH - 1) || s_ready_o[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL full_pop got occ=%0d rdy=%b want %0d 1",
                     occupancy_o[0], s_ready_o[0], DEPTH - 1);
        end
        cycle();
        s_valid_i[0] = 1'b0;
        vectors++;
        if (occupancy_o[0] !== OW'(DEPTH - 1)) begin
            miscompares++;
            $display("FAIL full_push_next got occ=%0d want %0d",
                     occupancy_o[0], DEPTH - 1);
        end
        for (int k = 0; k < DEPTH - 1; k++) begin
            vectors++;
            if (m_valid_o[0] !== 1'b1 || q[0].size() == 0 ||
                m_data_o[0] !== q[0][0].d) begin
                miscompares++;
                $display("FAIL drain_%0d got v=%b d=%h", k, m_valid_o[0], m_data_o[0]);
            end
            cycle();
        end
        vectors++;
        if (m_valid_o[0] !== 1'b0 || q[0].size() != 0) begin
            miscompares++;
            $display("FAIL drain_end got v=%b model=%0d want 0 0",
                     m_valid_o[0], q[0].size());
        end
        m_ready_i[0] = 1'b0;
    endtask

    task automatic test_streaming();
        int bad = 0;
        m_ready_i[0] = 1'b1;
        s_valid_i[0] = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            s_data_i[0] = DW'(i);
            s_size_i[0] = SW'(i);
            s_vc_i[0]   = VW'(i);
            cycle();
            vectors++;
            if (m_valid_o[0] !== 1'b1 || m_data_o[0] !== DW'(i) ||
                m_vc_o[0] !== VW'(i) || occupancy_o[0] !== OW'(1) ||
                s_ready_o[0] !== 1'b1) begin
                miscompares++;
                if (bad++ < 5)
                    $display("FAIL stream_%0d got v=%b d=%h occ=%0d rdy=%b want 1 %h 1 1",
                             i, m_valid_o[0], m_data_o[0], occupancy_o[0],
                             s_ready_o[0], DW'(i));
            end
        end
        s_valid_i[0] = 1'b0;
        cycle();
        m_ready_i[0] = 1'b0;
    endtask

    task automatic test_traffic(input int cycles, input bit stall1);
        int bad = 0;
        for (int n = 0; n < cycles; n++) begin
            for (int c = 0; c < NC; c++) begin
                s_valid_i[c] = ($urandom_range(0, 3) != 0);
                m_ready_i[c] = stall1 && c == 1 ? 1'b0 : ($urandom_range(0, 2) != 0);
                s_data_i[c]  = {$urandom, $urandom};
                s_size_i[c]  = SW'($urandom);
                s_vc_i[c]    = VW'($urandom);
            end
            #1;
            for (int c = 0; c < NC; c++) begin
                beat_t got;
                beat_t exp;
                int    sz;
                sz  = q[c].size();
                exp = sz != 0 ? q[c][0] : '0;
                got = {m_data_o[c], m_size_o[c], m_vc_o[c]};
                vectors++;
                if (m_valid_o[c] !== (sz != 0) || got !== exp ||
                    s_ready_o[c] !== (!m_rst && sz < DEPTH) ||
                    occupancy_o[c] !== OW'(sz) || afull_o[c] !== (sz >= AF)) begin
                    miscompares++;
                    if (bad++ < 5)
                        $display("FAIL traffic_c%0d t%0d got v=%b rdy=%b occ=%0d beat=%h want occ=%0d beat=%h",
                                 c, n, m_valid_o[c], s_ready_o[c], occupancy_o[c],
                                 got, sz, exp);
                end
`ifdef ECI_CHAN_BUF_STATS_EN
                vectors++;
                if (pkt_cnt_o[c] !== pk[c] || stall_cnt_o[c] !== st[c]) begin
                    miscompares++;
                    if (bad++ < 5)
                        $display("FAIL stats_c%0d t%0d got pkt=%0d stall=%0d want %0d %0d",
                                 c, n, pkt_cnt_o[c], stall_cnt_o[c], pk[c], st[c]);
                end
`endif
            end
            cycle();
        end
        s_valid_i = '0;
        m_ready_i = '1;
        repeat (DEPTH + 1) cycle();
        m_ready_i = '0;
    endtask

    task automatic test_reset_mid();
        m_ready_i    = '0;
        s_valid_i    = '0;
        s_valid_i[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data_i[0] = {$urandom, $urandom};
            cycle();
        end
        s_valid_i = '0;
        vectors++;
        if (occupancy_o[0] !== OW'(3)) begin
            miscompares++;
            $display("FAIL mid_fill got occ=%0d want 3", occupancy_o[0]);
        end
        reset = 1'b1;
        cycle();
        vectors++;
        if (s_ready_o !== '0 || m_valid_o !== '0 || afull_o !== '0 ||
            occupancy_o !== '0 || m_data_o !== '0) begin
            miscompares++;
            $display("FAIL mid_reset got rdy=%b v=%b af=%b occ=%h want 0",
                     s_ready_o, m_valid_o, afull_o, occupancy_o);
        end
        reset     = 1'b0;
        m_ready_i = '1;
        cycle();
        vectors++;
        if (s_ready_o !== '1 || m_valid_o !== '0) begin
            miscompares++;
            $display("FAIL mid_release got rdy=%b v=%b want 111 000",
                     s_ready_o, m_valid_o);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            vectors++;
            if (m_valid_o !== '0) begin
                miscompares++;
                $display("FAIL mid_quiet_%0d got v=%b want 000", k, m_valid_o);
            end
        end
        m_ready_i = '0;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_fill();
        test_streaming();
        test_traffic(300, 1'b1);
        test_traffic(400, 1'b0);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/eci_chan_buf.md
# eci_chan_buf

Parametrised single-clock buffer for a bundle of ECI packet channels (data, pkt_size, pkt_vc, valid/ready), replacing per-channel fixed-depth pipeline registers in the DCS datapath. Sits between the ECI channel interface and `dcs_2_axi` on the app clock. Each channel is an independent synchronous FIFO with registered control. Each channel provides occupancy and almost-full reporting, and optional traffic counters.

## Interface
- `NUM_CHAN`, 3: number of independent channels, ≥1.
- `DATA_WIDTH`, 64: payload bits per channel; `ECI_WORD_WIDTH * ECI_PACKET_SIZE` for with-data channels.
- `VC_WIDTH`, 4: VC field width; 5 for LCL channels.
- `DEPTH`, 4: entries per channel; power of two, ≥2.
- `AFULL_THRESH`, `DEPTH-1`: occupancy at or above which `afull_o` asserts; range 1..`DEPTH`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `s_data_i` in `[NUM_CHAN][DATA_WIDTH]`: ingress payload.
- `s_size_i` in `[NUM_CHAN][ECI_PACKET_SIZE_WIDTH]`: ingress packet size.
- `s_vc_i` in `[NUM_CHAN][VC_WIDTH]`: ingress VC.
- `s_valid_i` in `[NUM_CHAN]`: ingress valid.
- `s_ready_o` out `[NUM_CHAN]`: ingress ready.
- `m_data_o` out `[NUM_CHAN][DATA_WIDTH]`: egress payload.
- `m_size_o` out `[NUM_CHAN][ECI_PACKET_SIZE_WIDTH]`: egress size.
- `m_vc_o` out `[NUM_CHAN][VC_WIDTH]`: egress VC.
- `m_valid_o` out `[NUM_CHAN]`: egress valid.
- `m_ready_i` in `[NUM_CHAN]`: egress ready.
- `occupancy_o` out `[NUM_CHAN][$clog2(DEPTH+1)]`: entries held.
- `afull_o` out `[NUM_CHAN]`: occupancy ≥ `AFULL_THRESH`.
- `pkt_cnt_o` out `[NUM_CHAN][32]`: present only with `ECI_CHAN_BUF_STATS_EN`.
- `stall_cnt_o` out `[NUM_CHAN][32]`: present only with `ECI_CHAN_BUF_STATS_EN`.

## Operation
- **Per channel:**
  - Storage array of `DEPTH` beats of {data, size, vc}.
  - `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
  - `count` is `$clog2(DEPTH+1)` bits.
- **Push and pop:**
  - Push when `s_valid_i & s_ready_o`: write the beat at `wr_ptr`, then increment `wr_ptr`.
  - Pop when `m_valid_o & m_ready_i`: increment `rd_ptr`.
  - `count` is updated by +1 on push only, −1 on pop only, and is unchanged on both or neither.
- **Outputs:**
  - `s_ready_o = (count != DEPTH)`; there is no combinational path from `m_ready_i`.
  - `m_valid_o = (count != 0)`.
  - `m_data_o`/`m_size_o`/`m_vc_o` are taken from `storage[rd_ptr]` when `m_valid_o` is high, and are forced to 0 otherwise.
  - `occupancy_o = count`; `afull_o = (count >= AFULL_THRESH)`.
- **Boundary conditions:**
  - Full: push is refused even if a pop occurs in the same cycle; the slot becomes available the next cycle.
  - Empty: `m_ready_i` has no effect.
  - Simultaneous push and pop at non-full, non-empty: `count` is held and both pointers advance.
  - Channels never interact; no ordering is guaranteed across channels.
  - Packet fields are opaque; no check is made on size or VC.
- **Reset (synchronous):**
  - Clears pointers and counts on every channel.
  - While `reset` is high: `s_ready_o` = 0, `m_valid_o` = 0, `m_*` data = 0, `occupancy_o` = 0, `afull_o` = 0, counters = 0.
  - Storage is not reset.
  - Reset mid-operation discards all buffered beats; nothing is emitted afterwards.

## Timing
- Latency: a beat pushed at edge N is visible on `m_*` with `m_valid_o` = 1 after edge N (same cycle N+1).
- Throughput: one beat per cycle per channel is sustained indefinitely when `m_ready_i` is held high.
- `s_ready_o` rises the cycle after reset deasserts.
- All outputs are functions of registers only (a storage mux is allowed); no input-to-output combinational paths.

## Configuration
- `ECI_CHAN_BUF_STATS_EN`:
  - Defined: per-channel 32-bit counters are present.
    - `pkt_cnt_o` increments on each pop.
    - `stall_cnt_o` increments each cycle with `s_valid_i & ~s_ready_o`.
    - Both counters saturate at `32'hFFFF_FFFF` and clear on reset.
  - Undefined: the ports and logic are absent; the datapath is identical.

## Structure
- Package `eci_chan_buf_pkg` holds:
  - Function `occ_width(depth)` = `$clog2(depth+1)`.
  - Parametrised beat layout order: {data, size, vc}, with vc in the LSBs.
  - Statistics counter width constant `ECI_CHAN_BUF_CNT_WIDTH` = 32.
- Sub-module `eci_chan_fifo`: one channel's FIFO and counters.
- `eci_chan_buf` generates `NUM_CHAN` instances of `eci_chan_fifo`.
- Elaboration assertions: `DEPTH` is a power of two and ≥2; `AFULL_THRESH` is in range.

## Test plan
- Single beat: after reset, ch0 pushes data=0x1234, size=1, vc=6 at cycle 5 → `m_valid_o[0]`=1 in cycle 6 with matching fields; `occupancy_o[0]`=1 until popped.
- Fill: `DEPTH`=4 with `m_ready_i`=0 and 4 pushes → `s_ready_o` falls after the 4th push; `afull_o` rises at occupancy 3; a 5th valid beat is held and not lost.
- Full with simultaneous pop: at count=4, `s_valid_i`=1 and `m_ready_i`=1 → pop only, count=3; the push is accepted the next cycle.
- Streaming: 1000 beats of incrementing data with both sides always ready → one beat per cycle, in order, occupancy steady at 1, pointers wrap correctly.
- Channel independence: ch1 is stalled while ch0 and ch2 stream → ch0/ch2 unaffected, ch1 `stall_cnt_o` equals its stalled valid cycles (with STATS_EN), and `pkt_cnt_o` matches pops.
- Reset mid-operation: 3 beats buffered, `reset` pulsed for one cycle → outputs 0 during reset, `m_valid_o` stays 0 afterwards, `s_ready_o`=1 the following cycle.
